// File: rtl/fir_channel_scheduler.sv
// Round-robin job scheduler that time-shares one serial MAC FIR datapath
// between NCH sample channels: grant, load, LENGTH MACs, drain, write, report.
module fir_channel_scheduler #(
  parameter int NCH     = 4,
  parameter int CH_W    = 2,
  parameter int LENGTH  = 64,
  parameter int ADDR_W  = 6,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    input_valid,
  output logic [NCH-1:0]    in_ready,
  output logic [CH_W-1:0]   ch_sel,
  output logic              load_sample,
  output logic              acc_clr,
  output logic              mac_enb,
  output logic [ADDR_W-1:0] tap_addr,
  output logic              out_reg_enb,
  output logic              output_valid,
  output logic [CH_W-1:0]   output_ch,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam int CNT_W = (ADDR_W > DRN_W) ? ADDR_W : DRN_W;
  localparam logic [CNT_W-1:0] MAC_END = CNT_W'(LENGTH - 1);
  localparam logic [CNT_W-1:0] DRN_END = CNT_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CH_W-1:0]   r_ch_sel;
  logic [CH_W-1:0]   r_last;
  logic [CH_W-1:0]   r_out_ch;
  logic [CH_W-1:0]   w_grant;
  logic [NCH-1:0]    w_sel_vec;
  logic              w_any_req;
  logic              w_sel_req;

  // First requester strictly after 'last', wrapping; iterating downward keeps the nearest.
  function automatic logic [CH_W-1:0] rr_pick(input logic [NCH-1:0] req,
                                               input logic [CH_W-1:0] last);
    logic [CH_W-1:0] pick;
    logic [NCH-1:0]  sh;
    int              idx;
    pick = last;
    for (int k = NCH; k >= 1; k--) begin
      idx = (int'(last) + k) % NCH;
      sh  = req >> idx;
      if (sh[0]) pick = CH_W'(idx);
    end
    return pick;
  endfunction

  assign w_any_req = |input_valid;
  assign w_grant   = rr_pick(input_valid, r_last);
  assign w_sel_vec = input_valid >> r_ch_sel;
  assign w_sel_req = w_sel_vec[0];

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_LOAD;
      S_LOAD:  w_next = w_sel_req ? S_MAC : S_IDLE;
      S_MAC:   if (r_cnt == MAC_END) w_next = (MAC_LAT == 0) ? S_WRITE : S_DRAIN;
      S_DRAIN: if (r_cnt == DRN_END) w_next = S_WRITE;
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The counter restarts on every state change, so it serves both MAC taps and drain cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_ch_sel <= '0;
      r_last   <= CH_W'(NCH - 1);
      r_out_ch <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_ch_sel <= w_grant;
        r_last   <= w_grant;
      end
      if (r_state != w_next)
        r_cnt <= '0;
      else if (r_state == S_MAC || r_state == S_DRAIN)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_next == S_DONE)
        r_out_ch <= r_ch_sel;
    end
  end

  always_comb begin
    in_ready     = '0;
    load_sample  = 1'b0;
    acc_clr      = 1'b0;
    mac_enb      = 1'b0;
    tap_addr     = '0;
    out_reg_enb  = 1'b0;
    output_valid = 1'b0;
    ch_sel       = r_ch_sel;
    output_ch    = r_out_ch;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_LOAD: begin
        in_ready    = {{(NCH-1){1'b0}}, 1'b1} << r_ch_sel;
        load_sample = w_sel_req;
        acc_clr     = 1'b1;
      end
      S_MAC: begin
        mac_enb  = 1'b1;
        tap_addr = r_cnt[ADDR_W-1:0];
      end
      S_WRITE: out_reg_enb  = 1'b1;
      S_DONE:  output_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Bench for fir_channel_scheduler: a job-timeline reference model predicts every
// output each cycle from the grant cycle offset; directed scenarios then randomized traffic.
module tb_fir_channel_scheduler;

  localparam int NCH     = 4;
  localparam int CH_W    = 2;
  localparam int LENGTH  = 64;
  localparam int ADDR_W  = 6;
  localparam int MAC_LAT = 2;
  localparam int PH_WR   = LENGTH + MAC_LAT + 2;
  localparam int PH_DONE = LENGTH + MAC_LAT + 3;
  localparam int PERIOD  = LENGTH + MAC_LAT + 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    input_valid;
  logic [NCH-1:0]    in_ready;
  logic [CH_W-1:0]   ch_sel;
  logic              load_sample;
  logic              acc_clr;
  logic              mac_enb;
  logic [ADDR_W-1:0] tap_addr;
  logic              out_reg_enb;
  logic              output_valid;
  logic [CH_W-1:0]   output_ch;
  logic              busy;

  fir_channel_scheduler #(
    .NCH(NCH), .CH_W(CH_W), .LENGTH(LENGTH), .ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk(clk), .rst(rst), .input_valid(input_valid), .in_ready(in_ready),
    .ch_sel(ch_sel), .load_sample(load_sample), .acc_clr(acc_clr),
    .mac_enb(mac_enb), .tap_addr(tap_addr), .out_reg_enb(out_reg_enb),
    .output_valid(output_valid), .output_ch(output_ch), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec, n_err, cyc;
  // Model: m_phase = cycles since the grant cycle (0 = idle / grant cycle).
  int m_phase, m_last, m_ch, m_och, acc_ch;
  logic [NCH-1:0] hold_mask;
  int raise_pct, abort_pct, abort_ch, rst_tap, rst_hold;
  bit rnd_rst, rst_seen;
  int ov_cyc[$];
  int ov_ch[$];
  int c0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rr_next(input logic [NCH-1:0] req, input int last);
    logic [NCH-1:0] s;
    for (int k = 1; k <= NCH; k++) begin
      s = req >> ((last + k) % NCH);
      if (s[0]) return (last + k) % NCH;
    end
    return last;
  endfunction

  function automatic bit req_of(input logic [NCH-1:0] req, input int ch);
    logic [NCH-1:0] s;
    s = req >> ch;
    return s[0];
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_last  = NCH - 1;
    m_ch    = 0;
    m_och   = 0;
  endtask

  task automatic cycle_step();
    logic [31:0] e_ir, e_ld, e_clr, e_mac, e_tap, e_wr, e_ov, e_busy, e_och;
    @(negedge clk);
    e_ir = 0; e_ld = 0; e_clr = 0; e_mac = 0; e_tap = 0; e_wr = 0; e_ov = 0;
    e_busy = (m_phase >= 1) ? 1 : 0;
    e_och  = (m_phase == PH_DONE) ? m_ch : m_och;
    if (m_phase == 1) begin
      e_ir  = 32'(1) << m_ch;
      e_ld  = req_of(input_valid, m_ch) ? 1 : 0;
      e_clr = 1;
    end
    if (m_phase >= 2 && m_phase <= LENGTH + 1) begin
      e_mac = 1;
      e_tap = m_phase - 2;
    end
    if (m_phase == PH_WR)   e_wr = 1;
    if (m_phase == PH_DONE) e_ov = 1;
    check_eq("in_ready",     32'(in_ready),     e_ir);
    check_eq("ch_sel",       32'(ch_sel),       32'(m_ch));
    check_eq("load_sample",  32'(load_sample),  e_ld);
    check_eq("acc_clr",      32'(acc_clr),      e_clr);
    check_eq("mac_enb",      32'(mac_enb),      e_mac);
    check_eq("tap_addr",     32'(tap_addr),     e_tap);
    check_eq("out_reg_enb",  32'(out_reg_enb),  e_wr);
    check_eq("output_valid", 32'(output_valid), e_ov);
    check_eq("output_ch",    32'(output_ch),    e_och);
    check_eq("busy",         32'(busy),         e_busy);
    if (output_valid === 1'b1) begin
      ov_cyc.push_back(cyc);
      ov_ch.push_back(int'(output_ch));
    end
    acc_ch = -1;
    if (!rst) model_reset();
    else if (m_phase == 0) begin
      if (|input_valid) begin
        m_ch    = rr_next(input_valid, m_last);
        m_last  = m_ch;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (req_of(input_valid, m_ch)) begin
        acc_ch  = m_ch;
        m_phase = 2;
      end else m_phase = 0;
    end else if (m_phase == PH_DONE) begin
      m_och   = m_ch;
      m_phase = 0;
    end else m_phase++;
    @(posedge clk);
    cyc++;
    #1;
    if (rst_hold > 0) begin
      rst = 1'b0;
      rst_hold--;
    end else if (rst_tap >= 0 && m_phase == rst_tap + 2) begin
      rst = 1'b0;
      rst_seen = 1'b1;
    end else if (rnd_rst && $urandom_range(999) < 3) rst = 1'b0;
    else rst = 1'b1;
    if (acc_ch >= 0 && !req_of(hold_mask, acc_ch))
      input_valid = input_valid & ~(NCH'(1) << acc_ch);
    for (int i = 0; i < NCH; i++)
      if (!req_of(input_valid, i) && $urandom_range(99) < raise_pct)
        input_valid = input_valid | (NCH'(1) << i);
    if (m_phase == 1 && (m_ch == abort_ch || $urandom_range(99) < abort_pct))
      input_valid = input_valid & ~(NCH'(1) << m_ch);
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int g;
    g = 0;
    while (ov_ch.size() < n && g < budget) begin
      cycle_step();
      g++;
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    rst = 1'b0; input_valid = '1; hold_mask = '0;
    raise_pct = 0; abort_pct = 0; abort_ch = -1; rst_tap = -1; rst_hold = 2;
    rnd_rst = 0; rst_seen = 0; acc_ch = -1;
    @(posedge clk);
    #1;
    model_reset();

    // Reset held with every channel requesting
    repeat (3) cycle_step();

    // Contention: all four requests from reset release
    ov_cyc.delete(); ov_ch.delete();
    wait_outputs(4, 400);
    check_eq("cont_count", 32'(ov_ch.size()), 32'd4);
    for (int i = 0; i < ov_ch.size(); i++) check_eq("cont_ch", 32'(ov_ch[i]), 32'(i));
    for (int i = 1; i < ov_cyc.size(); i++)
      check_eq("cont_gap", 32'(ov_cyc[i] - ov_cyc[i-1]), 32'(PERIOD));

    // Fairness: channels 0 and 3 held continuously
    ov_cyc.delete(); ov_ch.delete();
    hold_mask = 4'b1001; input_valid = 4'b1001;
    wait_outputs(6, 600);
    input_valid = '0; hold_mask = '0;
    check_eq("fair_count", 32'(ov_ch.size()), 32'd6);
    for (int i = 0; i < ov_ch.size(); i++)
      check_eq("fair_ch", 32'(ov_ch[i]), (i % 2 == 0) ? 32'd0 : 32'd3);

    // Single job on channel 2
    ov_cyc.delete(); ov_ch.delete();
    repeat (5) cycle_step();
    input_valid = 4'b0100;
    c0 = cyc;
    repeat (75) cycle_step();
    check_eq("single_count", 32'(ov_ch.size()), 32'd1);
    if (ov_ch.size() > 0) begin
      check_eq("single_lat", 32'(ov_cyc[0] - c0), 32'(LENGTH + MAC_LAT + 3));
      check_eq("single_ch", 32'(ov_ch[0]), 32'd2);
    end

    // Abort: channel 1 drops its request in LOAD
    ov_cyc.delete(); ov_ch.delete();
    abort_ch = 1; input_valid = 4'b0010;
    repeat (4) cycle_step();
    abort_ch = -1;
    check_eq("abort_no_out", 32'(ov_ch.size()), 32'd0);
    input_valid = 4'b0110;
    wait_outputs(2, 200);
    check_eq("abort_count", 32'(ov_ch.size()), 32'd2);
    if (ov_ch.size() == 2) begin
      check_eq("abort_next0", 32'(ov_ch[0]), 32'd2);
      check_eq("abort_next1", 32'(ov_ch[1]), 32'd1);
    end

    // Reset in the middle of a MAC run
    ov_cyc.delete(); ov_ch.delete();
    rst_seen = 0; rst_tap = 30; input_valid = 4'b0010;
    repeat (40) cycle_step();
    rst_tap = -1;
    check_eq("midrst_hit", 32'(rst_seen), 32'd1);
    check_eq("midrst_no_out", 32'(ov_ch.size()), 32'd0);
    input_valid = 4'b1001;
    wait_outputs(1, 100);
    check_eq("midrst_count", 32'(ov_ch.size()), 32'd1);
    if (ov_ch.size() > 0) check_eq("midrst_first", 32'(ov_ch[0]), 32'd0);

    // Randomized traffic with aborts and occasional resets
    ov_cyc.delete(); ov_ch.delete();
    raise_pct = 8; abort_pct = 10; rnd_rst = 1;
    repeat (3000) cycle_step();
    check_eq("rnd_jobs", (ov_ch.size() > 10) ? 32'd1 : 32'd0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
